// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states, iteration count and small operation-class helpers.
package mdu_pkg;

   // One iteration per operand bit.
   localparam int ITERS = 32;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIX  = 2'b10
   } state_e;

   function automatic logic op_is_div(input op_e op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic op_is_signed(input op_e op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// Pipeline-facing bus of the multiply/divide unit: launch, operands,
// HI/LO moves, status and the architectural HI/LO values.
interface mdu_hilo_if #(
   parameter int WIDTH = 32
);
   logic             Start;
   logic [1:0]       Op;
   logic [WIDTH-1:0] OpA;
   logic [WIDTH-1:0] OpB;
   logic             MtHi;
   logic             MtLo;
   logic [WIDTH-1:0] MtData;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] Hi;
   logic [WIDTH-1:0] Lo;

   modport master (
      output Start, Op, OpA, OpB, MtHi, MtLo, MtData,
      input  Busy, Done, Hi, Lo
   );

   modport slave (
      input  Start, Op, OpA, OpB, MtHi, MtLo, MtData,
      output Busy, Done, Hi, Lo
   );
endinterface

// File: rtl/mdu_step.sv
// One combinational iteration: LSB-first shift-add for multiply, or one
// MSB-first restoring-divide step (dividend register fills with quotient bits).
module mdu_step #(
   parameter int WIDTH = 32
) (
   input  logic               is_div,
   input  logic [2*WIDTH-1:0] acc_i,
   input  logic [WIDTH:0]     rem_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic [2*WIDTH-1:0] acc_o,
   output logic [WIDTH:0]     rem_o,
   output logic [WIDTH-1:0]   a_o,
   output logic [WIDTH-1:0]   b_o
);
   logic [WIDTH:0]   sum_s;
   logic [WIDTH+1:0] shl_s;
   logic [WIDTH+1:0] diff_s;

   // Add into the upper half then shift right; a non-negative trial difference sets the quotient bit.
   always_comb begin
      sum_s  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (b_i[0] ? {1'b0, a_i} : {(WIDTH+1){1'b0}});
      shl_s  = {rem_i, a_i[WIDTH-1]};
      diff_s = shl_s - {2'b00, b_i};
      acc_o  = acc_i;
      rem_o  = rem_i;
      a_o    = a_i;
      b_o    = b_i;
      if (is_div) begin
         a_o   = {a_i[WIDTH-2:0], ~diff_s[WIDTH+1]};
         rem_o = diff_s[WIDTH+1] ? shl_s[WIDTH:0] : diff_s[WIDTH:0];
      end else begin
         acc_o = {sum_s, acc_i[WIDTH-1:1]};
         b_o   = {1'b0, b_i[WIDTH-1:1]};
      end
   end
endmodule

// File: rtl/mdu_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO pair;
// 33 busy cycles per operation, Done pulses once HI/LO carry the result.
module mdu_hilo
   import mdu_pkg::*;
#(
   parameter int WIDTH = ITERS
) (
   input  logic      Clk,
   input  logic      Rst_n,
   mdu_hilo_if.slave bus
);
   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e             state_q, state_d;
   op_e                op_q, op_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH:0]     rem_q, rem_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               busy_q, busy_d, done_q, done_d;

   logic [2*WIDTH-1:0] acc_step_s;
   logic [WIDTH:0]     rem_step_s;
   logic [WIDTH-1:0]   a_step_s, b_step_s;
   op_e                op_in_s;
   logic               signed_in_s, is_signed_s, neg_res_s;
   logic [2*WIDTH-1:0] prod_fix_s;
   logic [WIDTH-1:0]   quo_fix_s, rem_fix_s;

   mdu_step #(.WIDTH(WIDTH)) u_step (
      .is_div (op_is_div(op_q)),
      .acc_i  (acc_q),
      .rem_i  (rem_q),
      .a_i    (a_q),
      .b_i    (b_q),
      .acc_o  (acc_step_s),
      .rem_o  (rem_step_s),
      .a_o    (a_step_s),
      .b_o    (b_step_s)
   );

   assign op_in_s     = op_e'(bus.Op);
   assign signed_in_s = op_is_signed(op_in_s);
   assign is_signed_s = op_is_signed(op_q);
   // Quotient/product negate on sign mismatch; remainder follows the dividend.
   assign neg_res_s   = is_signed_s && (sign_a_q ^ sign_b_q);
   assign prod_fix_s  = neg_res_s ? -acc_q : acc_q;
   assign quo_fix_s   = neg_res_s ? -a_q : a_q;
   assign rem_fix_s   = (is_signed_s && sign_a_q) ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

   // Next-state, datapath and HI/LO update.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      rem_d    = rem_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      case (state_q)
         IDLE: begin
            if (bus.Start) begin
               op_d     = op_in_s;
               sign_a_d = signed_in_s && bus.OpA[WIDTH-1];
               sign_b_d = signed_in_s && bus.OpB[WIDTH-1];
               a_d      = (signed_in_s && bus.OpA[WIDTH-1]) ? -bus.OpA : bus.OpA;
               b_d      = (signed_in_s && bus.OpB[WIDTH-1]) ? -bus.OpB : bus.OpB;
               acc_d    = {(2*WIDTH){1'b0}};
               rem_d    = {(WIDTH+1){1'b0}};
               cnt_d    = {CW{1'b0}};
               state_d  = RUN;
            end else begin
               hi_d = bus.MtHi ? bus.MtData : hi_q;
               lo_d = bus.MtLo ? bus.MtData : lo_q;
            end
         end
         RUN: begin
            acc_d   = acc_step_s;
            rem_d   = rem_step_s;
            a_d     = a_step_s;
            b_d     = b_step_s;
            cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            state_d = (cnt_q == LAST) ? FIX : RUN;
         end
         FIX: begin
            if (op_is_div(op_q)) begin
               hi_d = rem_fix_s;
               lo_d = quo_fix_s;
            end else begin
               hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
               lo_d = prod_fix_s[WIDTH-1:0];
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_q == FIX);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q  <= IDLE;
         op_q     <= OP_MULT;
         cnt_q    <= {CW{1'b0}};
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         a_q      <= {WIDTH{1'b0}};
         b_q      <= {WIDTH{1'b0}};
         acc_q    <= {(2*WIDTH){1'b0}};
         rem_q    <= {(WIDTH+1){1'b0}};
         hi_q     <= {WIDTH{1'b0}};
         lo_q     <= {WIDTH{1'b0}};
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         rem_q    <= rem_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.Busy = busy_q;
   assign bus.Done = done_q;
   assign bus.Hi   = hi_q;
   assign bus.Lo   = lo_q;
endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: vector table plus hand-written sequences
// for moves, disturbances, mid-operation reset and back-to-back launches.
module tb_mdu_hilo;
   import mdu_pkg::*;

   localparam int W = 32;

   logic Clk   = 1'b0;
   logic Rst_n = 1'b0;

   mdu_hilo_if #(.WIDTH(W)) bus ();

   mdu_hilo #(.WIDTH(W)) dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      string       name;
   } vec_t;

   vec_t        vecs[$];
   logic [63:0] exp_q[$];
   int          errors = 0;
   int          checks = 0;
   time         last_done_t = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, q, r;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: res = 64'(sa * sb);
         2'b01: res = {32'd0, a} * {32'd0, b};
         2'b10: begin
            if (b == 32'd0) begin
               res = {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
            end else begin
               q   = sa / sb;
               r   = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else            res = {a % b, a / b};
         end
      endcase
      return res;
   endfunction

   // Called at a negedge with the unit idle; returns at the negedge of the Done cycle.
   // mode 1: pulse Start/MtHi/MtLo mid-run; mode 2: MtLo together with Start.
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string name, input int mode);
      logic [63:0] sb;
      logic [31:0] hi0, lo0;
      int busy_cnt = 0;
      int done_at  = 0;
      hi0 = bus.Hi;
      lo0 = bus.Lo;
      bus.Start = 1'b1;
      bus.Op    = op;
      bus.OpA   = a;
      bus.OpB   = b;
      if (mode == 2) begin
         bus.MtLo   = 1'b1;
         bus.MtData = 32'h0BAD_0BAD;
      end
      exp_q.push_back(exp);
      for (int n = 1; n <= 40; n++) begin
         @(negedge Clk);
         if (n == 1) begin
            bus.Start = 1'b0;
            bus.MtLo  = 1'b0;
            bus.OpA   = $urandom;
            bus.OpB   = $urandom;
            bus.Op    = 2'($urandom_range(3, 0));
            if (mode == 2) check({name, "_start_beats_mtlo"}, {32'd0, bus.Lo}, {32'd0, lo0});
         end
         if (mode == 1 && n == 10) begin
            bus.Start  = 1'b1;
            bus.MtHi   = 1'b1;
            bus.MtLo   = 1'b1;
            bus.MtData = 32'hDEAD_BEEF;
         end
         if (mode == 1 && n == 11) begin
            bus.Start = 1'b0;
            bus.MtHi  = 1'b0;
            bus.MtLo  = 1'b0;
            check({name, "_hilo_hold"}, {bus.Hi, bus.Lo}, {hi0, lo0});
         end
         if (bus.Done) begin
            done_at = n;
            break;
         end
         if (bus.Busy) busy_cnt++;
      end
      check({name, "_done_latency"}, 64'(done_at), 64'd34);
      check({name, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
      check({name, "_busy_low_at_done"}, {63'd0, bus.Busy}, 64'd0);
      sb = exp_q.pop_front();
      check({name, "_hilo"}, {bus.Hi, bus.Lo}, sb);
      last_done_t = $time;
   endtask

   initial begin
      time t1;
      int  seen;
      logic [1:0]  rop;
      logic [31:0] ra, rb;

      vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"});
      vecs.push_back('{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_m3x7"});
      vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7d2"});
      vecs.push_back('{2'b11, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, "divu_by_zero"});
      vecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_overflow"});
      vecs.push_back('{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minsq"});
      vecs.push_back('{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7dm2"});
      vecs.push_back('{2'b11, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF, "divu_max_by1"});
      vecs.push_back('{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, "multu_carry"});

      bus.Start  = 1'b0;
      bus.Op     = 2'b00;
      bus.OpA    = 32'd0;
      bus.OpB    = 32'd0;
      bus.MtHi   = 1'b0;
      bus.MtLo   = 1'b0;
      bus.MtData = 32'd0;
      Rst_n      = 1'b0;
      repeat (2) @(negedge Clk);
      check("reset_busy", {63'd0, bus.Busy}, 64'd0);
      check("reset_done", {63'd0, bus.Done}, 64'd0);
      check("reset_hilo", {bus.Hi, bus.Lo}, 64'd0);
      Rst_n = 1'b1;
      @(negedge Clk);

      bus.MtHi   = 1'b1;
      bus.MtData = 32'h0000_1234;
      @(negedge Clk);
      bus.MtHi = 1'b0;
      check("mthi", {bus.Hi, bus.Lo}, {32'h0000_1234, 32'd0});
      bus.MtLo   = 1'b1;
      bus.MtData = 32'h0000_5678;
      @(negedge Clk);
      bus.MtLo = 1'b0;
      check("mtlo", {bus.Hi, bus.Lo}, {32'h0000_1234, 32'h0000_5678});
      @(negedge Clk);

      foreach (vecs[i]) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo}, vecs[i].name, 0);
      end

      for (int i = 0; i < 6; i++) begin
         rop = 2'(i % 4);
         ra  = $urandom;
         rb  = $urandom;
         if (rb == 32'd0) rb = 32'd3;
         do_op(rop, ra, rb, model(rop, ra, rb), $sformatf("rand%0d", i), 0);
      end

      do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, "mult_disturbed", 1);
      repeat (3) @(negedge Clk);
      check("no_restart_after_disturb", {62'd0, bus.Busy, bus.Done}, 64'd0);

      do_op(OP_DIVU, 32'd17, 32'd5, {32'd2, 32'd3}, "divu_with_mtlo", 2);
      @(negedge Clk);

      do_op(OP_MULTU, 32'd3, 32'd5, {32'd0, 32'd15}, "b2b_multu", 0);
      t1 = last_done_t;
      do_op(OP_DIVU, 32'd17, 32'd5, {32'd2, 32'd3}, "b2b_divu", 0);
      check("b2b_spacing", 64'(last_done_t - t1), 64'd340);

      bus.Start = 1'b1;
      bus.Op    = OP_DIVU;
      bus.OpA   = 32'd1000;
      bus.OpB   = 32'd7;
      for (int n = 1; n <= 10; n++) begin
         @(negedge Clk);
         if (n == 1) bus.Start = 1'b0;
      end
      Rst_n = 1'b0;
      @(negedge Clk);
      Rst_n = 1'b1;
      check("abort_busy", {63'd0, bus.Busy}, 64'd0);
      check("abort_done", {63'd0, bus.Done}, 64'd0);
      check("abort_hilo", {bus.Hi, bus.Lo}, 64'd0);
      seen = 0;
      repeat (40) begin
         @(negedge Clk);
         if (bus.Done) seen++;
      end
      check("abort_no_done", 64'(seen), 64'd0);
      do_op(OP_DIVU, 32'd1000, 32'd7, {32'd6, 32'd142}, "divu_after_abort", 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
